// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: 3-stage radix-2 complex butterfly (DIT/DIF) with valid/ready stall, rounding and saturation.
module fft_bfly_pipe #(
    parameter int DATA_INP_WD = 16,
    parameter int DATA_OUT_WD = 16,
    parameter int WN_WD       = 16,
    parameter int WN_FRA_WD   = 14
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_val_i,
    output logic                     in_rdy_o,
    input  logic [2*DATA_INP_WD-1:0] fft_dat1_i,
    input  logic [2*DATA_INP_WD-1:0] fft_dat2_i,
    input  logic [2*WN_WD-1:0]       fft_wn_i,
    input  logic                     mode_i,
    input  logic                     scale_i,
    input  logic                     rnd_i,
    output logic                     out_val_o,
    input  logic                     out_rdy_i,
    output logic [2*DATA_OUT_WD-1:0] fft_dat1_o,
    output logic [2*DATA_OUT_WD-1:0] fft_dat2_o,
    output logic                     ovf_o,
    input  logic                     clr_ovf_i
);
    localparam int XW     = DATA_INP_WD + 1;
    localparam int PW     = XW + WN_WD;
    localparam int ACC_WD = DATA_INP_WD + WN_WD + 2;
    localparam logic signed [ACC_WD-1:0] ZERO = '0;
    localparam logic signed [ACC_WD-1:0] RND0 = ACC_WD'(1) << (WN_FRA_WD - 1);
    localparam logic signed [ACC_WD-1:0] RND1 = ACC_WD'(1) << WN_FRA_WD;
    localparam logic signed [ACC_WD-1:0] MAXV = {{(ACC_WD-DATA_OUT_WD+1){1'b0}}, {(DATA_OUT_WD-1){1'b1}}};
    localparam logic signed [ACC_WD-1:0] MINV = ~MAXV;

    function automatic logic [DATA_OUT_WD:0] fin(input logic signed [ACC_WD-1:0] v, input logic sc, input logic rn);
        logic signed [ACC_WD-1:0] s;
        s = v + (rn ? (sc ? RND1 : RND0) : ZERO);
        s = sc ? s >>> (WN_FRA_WD + 1) : s >>> WN_FRA_WD;
        return s > MAXV ? {1'b1, MAXV[DATA_OUT_WD-1:0]} :
               s < MINV ? {1'b1, MINV[DATA_OUT_WD-1:0]} : {1'b0, s[DATA_OUT_WD-1:0]};
    endfunction

    logic en;
    logic signed [DATA_INP_WD-1:0] ar, ai, br, bi;
    logic signed [WN_WD-1:0]       wr, wi;
    logic                          v1, m1, sc1, rn1;
    logic signed [XW-1:0]          pr1, pi1, xr1, xi1;
    logic signed [WN_WD-1:0]       wr1, wi1;
    logic                          v2, m2, sc2, rn2;
    logic signed [XW-1:0]          pr2, pi2;
    logic signed [PW-1:0]          rr2, ii2, ri2, ir2;
    logic signed [ACC_WD-1:0]      pre, pie, mre, mim, v1r, v1i, v2r, v2i;
    logic [DATA_OUT_WD:0]          f1r, f1i, f2r, f2i;

    assign en       = ~out_val_o | out_rdy_i;
    assign in_rdy_o = en;
    assign {ar, ai} = fft_dat1_i;
    assign {br, bi} = fft_dat2_i;
    assign {wr, wi} = fft_wn_i;

    // DIF folds a+b / a-b into capture so S2 always multiplies x = (DIT ? b : a-b) by w
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {v1, m1, sc1, rn1} <= '0;
            {pr1, pi1, xr1, xi1, wr1, wi1} <= '0;
        end else if (en) begin
            v1  <= in_val_i;
            m1  <= mode_i;
            sc1 <= scale_i;
            rn1 <= rnd_i;
            pr1 <= mode_i ? XW'(ar) + XW'(br) : XW'(ar);
            pi1 <= mode_i ? XW'(ai) + XW'(bi) : XW'(ai);
            xr1 <= mode_i ? XW'(ar) - XW'(br) : XW'(br);
            xi1 <= mode_i ? XW'(ai) - XW'(bi) : XW'(bi);
            wr1 <= wr;
            wi1 <= wi;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {v2, m2, sc2, rn2} <= '0;
            {pr2, pi2, rr2, ii2, ri2, ir2} <= '0;
        end else if (en) begin
            v2  <= v1;
            m2  <= m1;
            sc2 <= sc1;
            rn2 <= rn1;
            pr2 <= pr1;
            pi2 <= pi1;
            rr2 <= PW'(xr1) * PW'(wr1);
            ii2 <= PW'(xi1) * PW'(wi1);
            ri2 <= PW'(xr1) * PW'(wi1);
            ir2 <= PW'(xi1) * PW'(wr1);
        end
    end

    assign pre = ACC_WD'(pr2) <<< WN_FRA_WD;
    assign pie = ACC_WD'(pi2) <<< WN_FRA_WD;
    assign mre = ACC_WD'(rr2) - ACC_WD'(ii2);
    assign mim = ACC_WD'(ri2) + ACC_WD'(ir2);
    assign v1r = m2 ? pre : pre + mre;
    assign v1i = m2 ? pie : pie + mim;
    assign v2r = m2 ? mre : pre - mre;
    assign v2i = m2 ? mim : pie - mim;
    assign f1r = fin(v1r, sc2, rn2);
    assign f1i = fin(v1i, sc2, rn2);
    assign f2r = fin(v2r, sc2, rn2);
    assign f2i = fin(v2i, sc2, rn2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_val_o  <= 1'b0;
            fft_dat1_o <= '0;
            fft_dat2_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            if (en) begin
                out_val_o  <= v2;
                fft_dat1_o <= {f1r[DATA_OUT_WD-1:0], f1i[DATA_OUT_WD-1:0]};
                fft_dat2_o <= {f2r[DATA_OUT_WD-1:0], f2i[DATA_OUT_WD-1:0]};
            end
            ovf_o <= (en & v2 & (f1r[DATA_OUT_WD] | f1i[DATA_OUT_WD] | f2r[DATA_OUT_WD] | f2i[DATA_OUT_WD]))
                   | (ovf_o & ~clr_ovf_i);
        end
    end
endmodule

// File: tb/tb_fft_bfly_pipe.sv
// tb_fft_bfly_pipe: directed table vectors plus stall-stream and reset sequences for fft_bfly_pipe.
module tb_fft_bfly_pipe;
    typedef struct {
        logic [31:0] a, b, w;
        logic        mode, scale, rnd;
        logic [31:0] e1, e2;
        logic        eovf;
    } vec_t;

    logic        clk = 0, rstn = 0, in_val = 0, in_rdy, mode = 0, scale = 0, rnd = 0;
    logic        out_val, out_rdy = 1, ovf, clr_ovf = 0;
    logic [31:0] dat1 = 0, dat2 = 0, wn = 0, o1, o2;
    int          errors = 0, checks = 0;
    vec_t        tv[12];
    vec_t        sv[10];

    always #5 clk = ~clk;

    fft_bfly_pipe dut (
        .clk(clk), .rstn(rstn), .in_val_i(in_val), .in_rdy_o(in_rdy),
        .fft_dat1_i(dat1), .fft_dat2_i(dat2), .fft_wn_i(wn),
        .mode_i(mode), .scale_i(scale), .rnd_i(rnd),
        .out_val_o(out_val), .out_rdy_i(out_rdy),
        .fft_dat1_o(o1), .fft_dat2_o(o2), .ovf_o(ovf), .clr_ovf_i(clr_ovf)
    );

    function automatic logic [31:0] pk(input int re, input int im);
        logic [31:0] r;
        r = {re[15:0], im[15:0]};
        return r;
    endfunction

    function automatic vec_t mk(input int ar, input int ai, input int br, input int bi, input int wr, input int wi,
                                input logic md, input logic sc, input logic rn,
                                input int e1r, input int e1i, input int e2r, input int e2i, input logic eo);
        vec_t v;
        v.a = pk(ar, ai);
        v.b = pk(br, bi);
        v.w = pk(wr, wi);
        v.mode = md;
        v.scale = sc;
        v.rnd = rn;
        v.e1 = pk(e1r, e1i);
        v.e2 = pk(e2r, e2i);
        v.eovf = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dat1 = v.a;
        dat2 = v.b;
        wn = v.w;
        mode = v.mode;
        scale = v.scale;
        rnd = v.rnd;
    endtask

    // one set in, controls flipped right after capture, result checked exactly 3 edges later
    task automatic run(input vec_t v, input string nm);
        @(negedge clk);
        drive(v);
        in_val = 1;
        @(negedge clk);
        in_val = 0;
        mode = ~v.mode;
        scale = ~v.scale;
        rnd = ~v.rnd;
        @(negedge clk);
        chk({nm, "_early"}, 65'(out_val), 65'(0));
        @(negedge clk);
        chk({nm, "_val"}, 65'(out_val), 65'(1));
        chk({nm, "_out"}, {1'b0, o1, o2}, {1'b0, v.e1, v.e2});
        chk({nm, "_ovf"}, 65'(ovf), 65'(v.eovf));
    endtask

    initial begin
        int idx, oidx, cyc;
        logic prev_stall;
        logic [63:0] prev_o;
        tv[0]  = mk(1000, -500, 200, 300, 16384, 0, 0, 0, 0, 1200, -200, 800, -800, 0);
        tv[1]  = mk(0, 0, 100, 0, 0, -16384, 0, 0, 0, 0, -100, 0, 100, 0);
        tv[2]  = mk(0, 0, 3, 0, 8192, 0, 0, 0, 0, 1, 0, -2, 0, 0);
        tv[3]  = mk(0, 0, 3, 0, 8192, 0, 0, 0, 1, 2, 0, -1, 0, 0);
        tv[4]  = mk(32767, 0, 32767, 0, 16384, 0, 1, 0, 0, 32767, 0, 0, 0, 1);
        tv[5]  = mk(32767, 0, 32767, 0, 16384, 0, 1, 1, 0, 32767, 0, 0, 0, 0);
        tv[6]  = mk(1000, -500, 200, 300, 16384, 0, 0, 1, 0, 600, -100, 400, -400, 0);
        tv[7]  = mk(1000, -500, 200, 300, 0, 16384, 0, 0, 0, 700, -300, 1300, -700, 0);
        tv[8]  = mk(-32768, -32768, -32768, 0, 16384, 0, 0, 0, 0, -32768, -32768, 0, -32768, 1);
        tv[9]  = mk(300, 100, 100, 50, 0, -16384, 1, 0, 0, 400, 150, 50, -200, 0);
        tv[10] = mk(3, 0, 0, 0, 8192, 0, 1, 0, 1, 3, 0, 2, 0, 0);
        tv[11] = mk(5, 0, 2, 0, 16384, 0, 1, 1, 1, 4, 0, 2, 0, 0);
        for (int k = 1; k <= 10; k++)
            sv[k-1] = (k % 2) ? mk(100*k, -k, k, 2*k, 0, 16384, 1, 0, 0, 101*k, k, 3*k, 99*k, 0)
                              : mk(100*k, -k, k, 2*k, 0, 16384, 0, 0, 0, 98*k, 0, 102*k, -2*k, 0);

        @(negedge clk);
        chk("rst_val", 65'(out_val), 65'(0));
        chk("rst_rdy", 65'(in_rdy), 65'(1));
        chk("rst_dat", {1'b0, o1, o2}, 65'(0));
        chk("rst_ovf", 65'(ovf), 65'(0));
        rstn = 1;

        for (int i = 0; i < 12; i++) begin
            run(tv[i], $sformatf("vec%0d", i));
            clr_ovf = 1;
            @(negedge clk);
            clr_ovf = 0;
            chk("ovf_clr", 65'(ovf), 65'(0));
        end

        run(tv[4], "sticky");
        repeat (3) begin
            @(negedge clk);
            chk("ovf_hold", 65'(ovf), 65'(1));
        end
        clr_ovf = 1;
        @(negedge clk);
        clr_ovf = 0;
        chk("ovf_cleared", 65'(ovf), 65'(0));
        clr_ovf = 1;
        run(tv[4], "set_wins");
        @(negedge clk);
        chk("clr_after_set", 65'(ovf), 65'(0));
        clr_ovf = 0;

        idx = 0;
        oidx = 0;
        cyc = 0;
        prev_stall = 0;
        prev_o = '0;
        while (oidx < 10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            out_rdy = ($urandom_range(0, 2) != 0);
            if (idx < 10) begin
                drive(sv[idx]);
                in_val = 1;
            end else in_val = 0;
            #1;
            chk("rdy_rule", 65'(in_rdy), 65'(!(out_val && !out_rdy)));
            if (prev_stall) chk("stall_hold", {out_val, o1, o2}, {1'b1, prev_o});
            if (out_val && out_rdy) begin
                chk($sformatf("stream%0d", oidx), {1'b0, o1, o2}, {1'b0, sv[oidx].e1, sv[oidx].e2});
                oidx++;
            end
            if (in_val && in_rdy) idx++;
            prev_stall = out_val && !out_rdy;
            prev_o = {o1, o2};
        end
        chk("stream_count", 65'(oidx), 65'(10));
        in_val = 0;
        out_rdy = 1;
        repeat (3) @(negedge clk);
        chk("stream_drain", 65'(out_val), 65'(0));

        @(negedge clk);
        drive(tv[4]);
        in_val = 1;
        @(negedge clk);
        drive(tv[0]);
        @(negedge clk);
        drive(tv[1]);
        @(negedge clk);
        in_val = 0;
        chk("pre_rst_val", 65'(out_val), 65'(1));
        rstn = 0;
        #1;
        chk("mid_rst_val", 65'(out_val), 65'(0));
        chk("mid_rst_rdy", 65'(in_rdy), 65'(1));
        chk("mid_rst_dat", {1'b0, o1, o2}, 65'(0));
        chk("mid_rst_ovf", 65'(ovf), 65'(0));
        @(negedge clk);
        chk("rst_hold", 65'(out_val), 65'(0));
        rstn = 1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", 65'(out_val), 65'(0));
        end
        run(tv[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_bfly_pipe.md
FFT_BFLY_PIPE -- requirements
Module: fft_bfly_pipe

Interface
REQ-001 Parameter DATA_INP_WD, default 16: width of each real/imag input component, signed two's complement.
REQ-002 Parameter DATA_OUT_WD, default 16: width of each real/imag output component, signed.
REQ-003 Parameter WN_WD, default 16: width of each twiddle component, signed.
REQ-004 Parameter WN_FRA_WD, default 14: fraction bits of the twiddle, so 1.0 = 2^WN_FRA_WD.
REQ-005 Port clk  input  1: sole clock; all state changes on the rising edge.
REQ-006 Port rstn  input  1: asynchronous, active-low reset.
REQ-007 Port in_val_i  input  1: input operand set valid.
REQ-008 Port in_rdy_o  output  1: block can accept an operand set this cycle.
REQ-009 Port fft_dat1_i / fft_dat2_i  input  2*DATA_INP_WD each: operands a, b packed {re, im}, re in the MSBs.
REQ-010 Port fft_wn_i  input  2*WN_WD: twiddle w packed {re, im}.
REQ-011 Port mode_i  input  1: 0 = DIT, 1 = DIF, sampled with the operands.
REQ-012 Port scale_i  input  1: 1 = extra arithmetic right shift by 1 on both outputs, sampled with the operands.
REQ-013 Port rnd_i  input  1: 0 = floor (truncate), 1 = round half up, sampled with the operands.
REQ-014 Port out_val_o  output  1: result valid.
REQ-015 Port out_rdy_i  input  1: downstream accepts the result.
REQ-016 Port fft_dat1_o / fft_dat2_o  output  2*DATA_OUT_WD each: results packed {re, im}.
REQ-017 Port ovf_o  output  1: sticky saturation flag.
REQ-018 Port clr_ovf_i  input  1: synchronous clear of ovf_o.

Function
REQ-019 DIT: out1 = a + b*w, out2 = a - b*w.
REQ-020 DIF: out1 = a + b, out2 = (a - b)*w.
REQ-021 Complex product: re = xr*wr - xi*wi, im = xr*wi + xi*wr, computed full precision without intermediate truncation.
REQ-022 Internal width ACC_WD = DATA_INP_WD + WN_WD + 2, sign-extended; non-product terms are left-shifted by WN_FRA_WD before add/sub.
REQ-023 Total right shift S = WN_FRA_WD + scale; floor = arithmetic shift; round = add 2^(S-1) and then shift.
REQ-024 Each component saturates independently to [-2^(DATA_OUT_WD-1), 2^(DATA_OUT_WD-1)-1].
REQ-025 Pipeline has 3 register stages: S1 operand/control capture (DIF computes a+b and a-b here); S2 four products registered; S3 add/sub, shift, round, saturate, output register.
REQ-026 Latency is exactly 3 clk edges from input handshake to out_val_o when no stall occurs; throughput is 1 per cycle.
REQ-027 Input handshake occurs when in_val_i & in_rdy_o; output handshake occurs when out_val_o & out_rdy_i.
REQ-028 Global enable en = ~out_val_o | out_rdy_i; all stages, including their valid bits, advance only when en; in_rdy_o = en.
REQ-029 While out_val_o & ~out_rdy_i, outputs and all stage registers hold stable.
REQ-030 Bubbles (invalid stages) advance with en; results leave in input order with none dropped or duplicated.
REQ-031 ovf_o sets on the cycle after any component of a valid result saturates in S3 (qualified by en).
REQ-032 clr_ovf_i clears ovf_o next cycle; simultaneous set and clear resolves to set.
REQ-033 mode_i, scale_i and rnd_i travel with their operand set; changes between sets never affect in-flight data.

Reset
REQ-034 While rstn = 0: all stage valids, out_val_o, ovf_o, fft_dat1_o and fft_dat2_o are 0; in_rdy_o = 1.
REQ-035 Reset asserted mid-operation discards all in-flight data; the first handshake after release produces the first result.

Verification
REQ-036 DIT, a=(1000,-500), b=(200,300), w=(16384,0), floor, no scale -> after 3 cycles out1=(1200,-200), out2=(800,-800).
REQ-037 DIT, b=(100,0), w=(0,-16384) (-j) -> b*w=(0,-100); a=(0,0) gives out1=(0,-100), out2=(0,100).
REQ-038 DIF, a=(32767,0), b=(32767,0), w=(16384,0), scale=0 -> out1.re saturates to 32767, ovf_o=1 until clr_ovf_i; with scale=1 -> out1.re=32767, no ovf.
REQ-039 Rounding: DIT, a=0, b=(3,0), w=(8192,0) -> product 1.5 gives out1.re=1 (floor) or 2 (round).
REQ-040 Back-to-back stream of 10 sets with out_rdy_i toggled pseudo-randomly -> all 10 results in order, outputs stable during stalls, in_rdy_o=0 exactly while out_val_o & ~out_rdy_i.
REQ-041 rstn pulsed low with 3 sets in flight -> out_val_o=0 immediately, no stale result after release.
